// File: rtl/hmmm_mem_pkg.sv
// Shared types and constants for the HMMM memory responder.
//   state_t     : responder FSM states. HALT reuses low code 3 so the 2-bit
//                 debug code stays compact; RUN and HALT are told apart by
//                 cpu_reset.
//   RDATA_MASK  : bit 15 of every stored word reads as 0.
//   WRITE_HI    : upper byte stored on a processor write.
package hmmm_mem_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'b000,
    StLoad = 3'b001,
    StHold = 3'b010,
    StRun  = 3'b011,
    StHalt = 3'b111
  } state_t;

  localparam logic [15:0] RDATA_MASK = 16'h7FFF;
  localparam logic [7:0]  WRITE_HI   = 8'h00;

  // Debug code: low two bits of the state encoding.
  function automatic logic [1:0] state_code(state_t s);
    return s[1:0];
  endfunction

endpackage

// File: rtl/hmmm_mem_store.sv
// Word store for the HMMM memory responder.
//   clk, reset_n : clock and async active-low reset (read register only)
//   we/waddr/wdata : single synchronous write port
//   re/raddr/rdata : registered read port, 1 clk latency, bit 15 masked
// The array itself is never reset so loaded programs survive a reset.
module hmmm_mem_store
  import hmmm_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr] & DATA_WIDTH'(RDATA_MASK);
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/hmmm_mem_responder.sv
// Memory-side responder for the HMMM processor bus on the test fixture.
//   Host side : ld_start/ld_valid/ld_ready/ld_data/ld_last load stream,
//               done/result_data/result_adr/write_count result reporting.
//   CPU side  : cpu_reset, mem_adr/mem_write/mem_wdata in,
//               mem_rdata/mem_rdata_oe out (PCB tristate enable).
//   Debug     : state_o.
// Flow: IDLE -> LOAD (program words) -> HOLD (cpu_reset held RESET_HOLD clks)
//       -> RUN (serve the processor) -> HALT on first write if HALT_ON_WRITE.
module hmmm_mem_responder
  import hmmm_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned RESET_HOLD    = 4,
  parameter int unsigned HALT_ON_WRITE = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  cpu_reset,
  input  logic [ADDR_WIDTH-1:0] mem_adr,
  input  logic                  mem_write,
  input  logic [7:0]            mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_rdata_oe,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result_data,
  output logic [ADDR_WIDTH-1:0] result_adr,
  output logic [7:0]            write_count,
  output logic [1:0]            state_o
);

  localparam int unsigned HoldW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HoldW-1:0]      HoldLast = HoldW'(RESET_HOLD - 1);
  localparam logic [ADDR_WIDTH-1:0] PtrMax   = '1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [HoldW-1:0]      hold_q, hold_d;
  logic                  wr_prev_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] result_data_q;
  logic [ADDR_WIDTH-1:0] result_adr_q;
  logic [7:0]            count_q;

  logic                  run;
  logic                  ld_accept;
  logic                  load_end;
  logic                  wr_edge;
  logic                  cpu_we;
  logic [DATA_WIDTH-1:0] cpu_word;
  logic                  st_we;
  logic [ADDR_WIDTH-1:0] st_waddr;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic                  st_re;

  assign run       = (state_q == StRun);
  assign ld_accept = (state_q == StLoad) && ld_valid;
  // The pointer never wraps: the last address ends the load on its own.
  assign load_end  = ld_accept && (ld_last || (ptr_q == PtrMax));
  assign wr_edge   = run && mem_write && !wr_prev_q;
  assign cpu_we    = run && mem_write;
  assign cpu_word  = DATA_WIDTH'({WRITE_HI, mem_wdata});

  // Load and CPU writes live in disjoint states, so a plain 2:1 mux suffices.
  assign st_we    = ld_accept || cpu_we;
  assign st_waddr = ld_accept ? ptr_q : mem_adr;
  assign st_wdata = ld_accept ? (ld_data & DATA_WIDTH'(RDATA_MASK)) : cpu_word;
  assign st_re    = run && !mem_write;

  hmmm_mem_store #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_store (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (st_we),
    .waddr   (st_waddr),
    .wdata   (st_wdata),
    .re      (st_re),
    .raddr   (mem_adr),
    .rdata   (mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle, StHalt: begin
        if (ld_start) begin
          state_d = StLoad;
          ptr_d   = '0;
        end
      end
      StLoad: begin
        if (load_end) begin
          state_d = StHold;
          hold_d  = '0;
        end else if (ld_accept) begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      StHold: begin
        if (hold_q == HoldLast) begin
          state_d = StRun;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StRun: begin
        if ((HALT_ON_WRITE != 0) && wr_edge) begin
          state_d = StHalt;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_prev_q     <= 1'b0;
      done_q        <= 1'b0;
      result_data_q <= '0;
      result_adr_q  <= '0;
      count_q       <= '0;
    end else begin
      wr_prev_q <= mem_write;
      done_q    <= wr_edge;
      if (load_end) begin
        // A new run starts with a clean result record (address is kept).
        count_q       <= '0;
        result_data_q <= '0;
      end else if (wr_edge) begin
        result_adr_q  <= mem_adr;
        result_data_q <= cpu_word;
        if (count_q != 8'hFF) begin
          count_q <= count_q + 8'd1;
        end
      end
    end
  end

  assign ld_ready     = (state_q == StLoad);
  assign cpu_reset    = (state_q != StRun);
  assign mem_rdata_oe = st_re;
  assign done         = done_q;
  assign result_data  = result_data_q;
  assign result_adr   = result_adr_q;
  assign write_count  = count_q;
  assign state_o      = state_code(state_q);

endmodule

// File: tb/tb_hmmm_mem_responder.sv
// Self-checking bench for hmmm_mem_responder: directed table load, read
// latency, write/result/halt, restart, reset, overflow load, mid-load abort
// and randomized load/read/write runs against a word-array model.
module tb_hmmm_mem_responder;

  localparam int RESET_HOLD = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ld_start, ld_valid, ld_last;
  logic        ld_ready;
  logic [15:0] ld_data;
  logic        cpu_reset;
  logic [7:0]  mem_adr;
  logic        mem_write;
  logic [7:0]  mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_rdata_oe;
  logic        done;
  logic [15:0] result_data;
  logic [7:0]  result_adr;
  logic [7:0]  write_count;
  logic [1:0]  state_o;

  hmmm_mem_responder #(
    .ADDR_WIDTH    (8),
    .DATA_WIDTH    (16),
    .RESET_HOLD    (RESET_HOLD),
    .HALT_ON_WRITE (1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ld_start     (ld_start),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .cpu_reset    (cpu_reset),
    .mem_adr      (mem_adr),
    .mem_write    (mem_write),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_rdata_oe (mem_rdata_oe),
    .done         (done),
    .result_data  (result_data),
    .result_adr   (result_adr),
    .write_count  (write_count),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  // Reference model: memory contents, which words are defined, run write count.
  logic [15:0] mdl   [256];
  bit          known [256];
  int          cnt_m;
  logic [15:0] ldq   [$];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] ld;
    logic [15:0] stored;
  } ld_vec_t;

  ld_vec_t tbl [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic do_load(input bit use_last, input bit gaps);
    int i;
    bit fin;
    bit v;
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    chk("load_state", 32'(state_o), 32'd1);
    chk("load_cpu_reset", 32'(cpu_reset), 32'd1);
    i   = 0;
    fin = 1'b0;
    while (!fin) begin
      v        = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      ld_valid = v;
      ld_data  = ldq[i];
      ld_last  = use_last && (i == ldq.size() - 1);
      chk("ld_ready", 32'(ld_ready), 32'd1);
      @(posedge clk);
      if (v) begin
        mdl[i]   = ldq[i] & 16'h7FFF;
        known[i] = 1'b1;
        if (ld_last || i == 255) fin = 1'b1;
        i++;
      end
      @(negedge clk);
    end
    // ld_valid is still high here: an extra word must not be taken.
    chk("hold_ld_ready", 32'(ld_ready), 32'd0);
    chk("hold_count_clr", 32'(write_count), 32'd0);
    chk("hold_result_clr", 32'(result_data), 32'd0);
    cnt_m    = 0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    for (int k = 0; k < RESET_HOLD; k++) begin
      chk("hold_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("hold_state", 32'(state_o), 32'd2);
      @(negedge clk);
    end
    chk("run_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("run_state", 32'(state_o), 32'd3);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [15:0] exp);
    mem_adr   = a;
    mem_write = 1'b0;
    @(negedge clk);
    chk("rd_data", 32'(mem_rdata), 32'(exp));
    chk("rd_oe", 32'(mem_rdata_oe), 32'd1);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int hold);
    int          dones;
    logic [15:0] w;
    dones     = 0;
    w         = {8'h00, d};
    mem_adr   = a;
    mem_wdata = d;
    mem_write = 1'b1;
    #1;
    chk("wr_oe_off", 32'(mem_rdata_oe), 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (k == 0) begin
        mdl[a]   = w;
        known[a] = 1'b1;
        cnt_m    = (cnt_m == 255) ? 255 : cnt_m + 1;
        chk("wr_result_adr", 32'(result_adr), 32'(a));
        chk("wr_result_data", 32'(result_data), 32'(w));
        chk("wr_count", 32'(write_count), 32'(cnt_m));
        chk("halt_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("halt_state", 32'(state_o), 32'd3);
      end
    end
    mem_write = 1'b0;
    chk("wr_done_pulses", 32'(dones), 32'd1);
    @(negedge clk);
    chk("wr_done_low", 32'(done), 32'd0);
    chk("halt_oe", 32'(mem_rdata_oe), 32'd0);
    chk("halt_result_held", 32'(result_data), 32'(w));
    chk("halt_count_held", 32'(write_count), 32'(cnt_m));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{ld: 16'h1234, stored: 16'h1234};
    tbl[1] = '{ld: 16'h8001, stored: 16'h0001};
    tbl[2] = '{ld: 16'h0042, stored: 16'h0042};
    for (int j = 0; j < 256; j++) known[j] = 1'b0;
    cnt_m = 0;

    reset_n   = 1'b0;
    ld_start  = 1'b0;
    ld_valid  = 1'b0;
    ld_last   = 1'b0;
    ld_data   = '0;
    mem_adr   = '0;
    mem_write = 1'b0;
    mem_wdata = '0;
    #12;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(write_count), 32'd0);
    chk("rst_rdata", 32'(mem_rdata), 32'd0);
    chk("rst_oe", 32'(mem_rdata_oe), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_cpu_reset", 32'(cpu_reset), 32'd1);

    // Directed table load, then read back through the CPU port.
    ldq.delete();
    for (int j = 0; j < 3; j++) ldq.push_back(tbl[j].ld);
    do_load(1'b1, 1'b0);
    for (int j = 0; j < 3; j++) do_read(8'(j), tbl[j].stored);

    // Write held for three clocks: one commit, one done, then HALT.
    do_write(8'h20, 8'h2D, 3);

    // Restart from HALT with a single word.
    ldq.delete();
    ldq.push_back(16'h0007);
    do_load(1'b1, 1'b0);
    do_read(8'h20, 16'h002D);
    do_read(8'h01, 16'h0001);
    do_read(8'h00, 16'h0007);

    // ld_start in RUN is ignored.
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    @(negedge clk);
    chk("run_ld_start_state", 32'(state_o), 32'd3);
    chk("run_ld_start_cpu_reset", 32'(cpu_reset), 32'd0);
    do_read(8'h02, 16'h0042);
    do_write(8'h55, 8'hA5, 1);

    // Asynchronous reset mid-cycle clears outputs at once.
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_state", 32'(state_o), 32'd0);
    chk("arst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_count", 32'(write_count), 32'd0);
    chk("arst_result_data", 32'(result_data), 32'd0);
    chk("arst_result_adr", 32'(result_adr), 32'd0);
    chk("arst_rdata", 32'(mem_rdata), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Overflow load: 256 words without ld_last.
    ldq.delete();
    for (int j = 0; j < 256; j++) ldq.push_back(16'($urandom));
    do_load(1'b0, 1'b0);
    do_read(8'hFF, mdl[255]);
    do_read(8'h80, mdl[128]);
    do_write(8'h10, 8'h3C, 2);

    // Mid-load reset aborts to IDLE and keeps the partial contents.
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    for (int j = 0; j < 2; j++) begin
      ld_valid = 1'b1;
      ld_data  = 16'($urandom);
      @(posedge clk);
      mdl[j] = ld_data & 16'h7FFF;
      @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    chk("abort_state", 32'(state_o), 32'd0);
    chk("abort_ld_ready", 32'(ld_ready), 32'd0);
    ld_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    ldq.delete();
    ldq.push_back(16'h4321);
    do_load(1'b1, 1'b0);
    do_read(8'h01, mdl[1]);
    do_read(8'h02, mdl[2]);
    do_write(8'h33, 8'h44, 1);

    // Randomized runs: load with valid gaps, random reads, one write each.
    for (int it = 0; it < 15; it++) begin
      int n;
      logic [7:0] a;
      n = int'($urandom_range(1, 16));
      ldq.delete();
      for (int j = 0; j < n; j++) ldq.push_back(16'($urandom));
      do_load(1'b1, 1'b1);
      for (int r = 0; r < 4; r++) begin
        a = 8'($urandom);
        if (known[a]) do_read(a, mdl[a]);
      end
      do_write(8'($urandom), 8'($urandom), int'($urandom_range(1, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hmmm_mem_responder.md
Name: hmmm_mem_responder

Overview:
- Synthesizable memory-side responder for the HMMM processor bus (Adr[7:0], MemWrite, MemData). It replaces the behavioural SRAM model on the FPGA/PCB test fixture.
- Preloads program words from a host load stream and holds the processor in reset while loading.
- Serves processor reads and writes from an internal 256x16 store.
- Captures processor writes as test results and reports completion to the host.

Parameters:
- ADDR_WIDTH, 8, processor address width; store depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 16, memory word width; bit 15 always reads 0.
- RESET_HOLD, 4, clk cycles cpu_reset stays high after loading ends.
- HALT_ON_WRITE, 1, if 1 the first processor write ends the run (enters HALT).

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ld_start  in  1  one-cycle pulse; begin a program load (accepted in IDLE or HALT).
- ld_valid  in  1  load word valid.
- ld_ready  out  1  responder can accept a load word.
- ld_data  in  DATA_WIDTH  load word.
- ld_last  in  1  marks the final load word.
- cpu_reset  out  1  active-high reset to the processor.
- mem_adr  in  ADDR_WIDTH  processor address.
- mem_write  in  1  processor MemWrite, active high.
- mem_wdata  in  8  processor write data (low byte).
- mem_rdata  out  DATA_WIDTH  read data to the processor.
- mem_rdata_oe  out  1  read-data drive enable for the PCB tristate.
- done  out  1  one-cycle pulse on a captured result write.
- result_data  out  DATA_WIDTH  last captured write word.
- result_adr  out  ADDR_WIDTH  address of the last captured write.
- write_count  out  8  number of processor writes this run; saturates at 255.
- state_o  out  2  current state, for debug.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; cpu_reset=1; ld_ready=0; mem_rdata=0; mem_rdata_oe=0.
  - done=0; result_data=0; result_adr=0; write_count=0.
  - The store contents are not reset.
- States are IDLE, LOAD, HOLD, RUN, HALT. The encodings are 0 to 3 for IDLE..RUN; HALT shares code 3 with bit pattern from the package (see Decomposition).
- IDLE:
  - cpu_reset=1.
  - ld_start moves to LOAD and clears the load pointer to 0.
- LOAD:
  - cpu_reset=1; ld_ready=1.
  - On ld_valid&ld_ready: store[ptr]<=ld_data with bit 15 forced to 0; ptr increments.
  - ld_last or ptr==2**ADDR_WIDTH-1 on an accepted word moves to HOLD. The pointer does not wrap.
  - Words not loaded keep their prior contents.
- HOLD:
  - cpu_reset=1 for exactly RESET_HOLD cycles, counted from entry, then moves to RUN.
  - Entering HOLD clears write_count and result_data.
- RUN:
  - cpu_reset=0.
  - Read path: when mem_write=0, mem_rdata<=store[mem_adr] is registered with 1 clk latency, and mem_rdata_oe=1.
  - The processor clock must run at 1/2 of clk or slower so the read data settles within its phase.
  - Write path: on the rising edge of mem_write (registered previous value 0, current 1):
    - store[mem_adr]<={8'h00,mem_wdata}.
    - result_adr and result_data capture the address and word.
    - done pulses for 1 cycle.
    - write_count increments, saturating at 255.
  - mem_write held high on later cycles rewrites the same value, with no further done or count.
  - mem_rdata_oe=0 while mem_write=1.
- HALT:
  - Entered when HALT_ON_WRITE=1, in the cycle after the write commit.
  - cpu_reset=1; mem_rdata_oe=0; result outputs are held.
  - ld_start moves to LOAD.
- ld_start in LOAD, HOLD or RUN is ignored. ld_valid outside LOAD is ignored.
- A simultaneous write edge and cpu_reset assertion cannot occur, because cpu_reset=0 only in RUN.
- reset_n deasserting mid-load aborts to IDLE; the partial store contents remain.

Decomposition:
- Package hmmm_mem_pkg holds:
  - state_t enum {IDLE, LOAD, HOLD, RUN, HALT}, with state_o carrying the low 2 bits plus HALT flagged via cpu_reset&~ld_ready.
  - Constant RDATA_MASK = 16'h7FFF.
  - Constant WRITE_HI = 8'h00.
- One sub-module, hmmm_mem_store:
  - 2**ADDR_WIDTH x DATA_WIDTH array.
  - One synchronous write port with 2:1 write-source muxing done in the parent.
  - One registered read port.
- The FSM, load pointer, hold counter, edge detector and result registers live in the parent.

Test Plan:
- Reset: assert reset_n=0 mid-cycle -> outputs clear immediately; cpu_reset=1, done=0, write_count=0, state IDLE.
- Load: ld_start, then 3 words 16'h1234, 16'h8001, 16'h0042 with ld_last on the third -> ld_ready high in LOAD. After load, store[0..2] = 16'h1234, 16'h0001 (bit 15 cleared), 16'h0042. cpu_reset stays 1 for 4 cycles after the last word, then 0.
- Read latency: in RUN, mem_adr=2, mem_write=0 -> mem_rdata=16'h0042 on the next clk edge with mem_rdata_oe=1.
- Write/result: mem_adr=8'h20, mem_wdata=8'h2D, mem_write held high 3 clks -> one done pulse, result_data=16'h002D, result_adr=8'h20, write_count=1, store[32]=16'h002D. With HALT_ON_WRITE=1, cpu_reset=1 on the following cycle.
- Overflow load: 256 words without ld_last -> HOLD entered after word 255; a 257th ld_valid is not accepted (ld_ready=0).
- Restart: from HALT, ld_start with 1 word (ld_last) -> write_count cleared to 0 on HOLD entry; RUN resumes. An ld_start pulse during RUN is ignored.
